// File: rtl/sha_msched_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message-schedule controller.
package sha_msched_ctrl_pkg;

    localparam int unsigned NWORDS   = 16;
    localparam int unsigned NSCHED   = 64;
    localparam int unsigned FEED_LAT = 17;
    localparam int unsigned GAP_CYC  = 1;

    localparam int unsigned IDX_W    = 6;
    localparam int unsigned BUF_AW   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FEED,
        GAP,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sha_msched_ctrl_wbuf.sv
// 16-entry message word buffer: written in LOAD order, read combinationally during FEED.
module msched_wbuf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents need no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sha_msched_ctrl.sv
// Sequences message blocks through an external schedule unit and streams W[0..63].
module sha_msched_ctrl
    import sha_msched_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned BLK_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLK_W-1:0]   nblocks,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               unit_run,
    output logic [DELAY_W-1:0] unit_delay,
    output logic [DATA_W-1:0]  unit_in,
    input  logic [DATA_W-1:0]  unit_out,
    output logic               w_valid,
    output logic [DATA_W-1:0]  w_data,
    output logic [5:0]         w_idx
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   nblk_q, nblk_d;

    logic               buf_we;
    logic [DATA_W-1:0]  buf_rdata;

    logic               busy_d, done_d, in_ready_d, unit_run_d, w_valid_d;
    logic [DATA_W-1:0]  unit_in_d, w_data_d;
    logic [5:0]         w_idx_d;

    msched_wbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (NWORDS),
        .ADDR_W (BUF_AW)
    ) u_wbuf (
        .clk     (clk),
        .we      (buf_we),
        .waddr   (cnt_q[BUF_AW-1:0]),
        .wdata   (in_data),
        .raddr   (cnt_d[BUF_AW-1:0]),
        .rdata_c (buf_rdata)
    );

    // State, phase counter and block bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            nblk_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            nblk_q  <= nblk_d;
        end
    end

    // Next state; outputs are computed for the state being entered so the registers are Moore-aligned.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        nblk_d     = nblk_q;
        buf_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nblk_d  = nblocks;
                    blk_d   = '0;
                    cnt_d   = '0;
                    state_d = (nblocks == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    buf_we = 1'b1;
                    if (cnt_q == IDX_W'(NWORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (cnt_q == IDX_W'(FEED_LAT - GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == IDX_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == IDX_W'(NSCHED - NWORDS - 1)) begin
                    cnt_d   = '0;
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = ((blk_q + BLK_W'(1)) < nblk_q) ? LOAD : DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        in_ready_d = (state_d == LOAD);
        unit_run_d = (state_d == RUN);
        w_valid_d  = 1'b0;
        unit_in_d  = '0;
        w_data_d   = '0;
        w_idx_d    = '0;

        if (state_d == FEED) begin
            w_valid_d = 1'b1;
            unit_in_d = buf_rdata;
            w_data_d  = buf_rdata;
            w_idx_d   = cnt_d;
        end else if (state_d == DRAIN) begin
            // unit_out carries the word computed during the preceding cycle.
            w_valid_d = 1'b1;
            w_data_d  = unit_out;
            w_idx_d   = cnt_d + IDX_W'(NWORDS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            unit_run <= 1'b0;
            w_valid  <= 1'b0;
            unit_in  <= '0;
            w_data   <= '0;
            w_idx    <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            in_ready <= in_ready_d;
            unit_run <= unit_run_d;
            w_valid  <= w_valid_d;
            unit_in  <= unit_in_d;
            w_data   <= w_data_d;
            w_idx    <= w_idx_d;
        end
    end

    assign unit_delay = '0;

endmodule

// File: doc/sha_msched_ctrl.md
SHA_MSCHED_CTRL -- requirements
Module: sha_msched_ctrl

Interface
REQ-001 SHALL use parameters: DATA_W, default 32, word width; DELAY_W, default 8, unit delay field width; BLK_W, default 16, block-count width.
REQ-002 SHALL have ports (name  direction  width  meaning), in this order:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job-start pulse
- nblocks  in  BLK_W  number of 512-bit blocks in the job
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- in_valid  in  1  message word valid
- in_ready  out  1  message word accepted
- in_data  in  DATA_W  message word
- unit_run  out  1  run pulse to schedule unit
- unit_delay  out  DELAY_W  schedule-unit delay configuration
- unit_in  out  DATA_W  word fed to schedule unit
- unit_out  in  DATA_W  schedule-unit output
- w_valid  out  1  schedule word valid
- w_data  out  DATA_W  schedule word W[t]
- w_idx  out  6  t, 0..63

Function
REQ-003 SHALL implement states IDLE, LOAD, RUN, FEED, GAP, DRAIN, DONE.
REQ-004 IDLE: start=1 latches nblocks and clears the block counter; next state is LOAD, or DONE when nblocks=0 (no unit_run issued). start is ignored in all other states.
REQ-005 LOAD: in_ready=1; each in_valid&in_ready cycle writes in_data to buffer entry k (k=0..15, incrementing); after the 16th accept, next state is RUN.
REQ-006 RUN: unit_run=1 for exactly one cycle (c0); unit_delay is held constant at 0 at all times.
REQ-007 FEED: cycles c1..c16; unit_in=buffer[k] in cycle c(k+1); w_valid=1, w_data=buffer[k], w_idx=k in the same cycle.
REQ-008 GAP: cycle c17, w_valid=0 (unit computing W16).
REQ-009 DRAIN: cycles c18..c65; w_valid=1, w_data=unit_out, w_idx=16+j in cycle c(18+j), j=0..47.
REQ-010 After c65, the block counter increments; next state is LOAD if blocks remain, otherwise DONE.
REQ-011 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-012 The w_* outputs have no backpressure; the consumer SHALL accept every w_valid cycle.
REQ-013 in_ready SHALL be 0 outside LOAD; a stalled producer extends LOAD indefinitely without corrupting previously accepted words.
REQ-014 The block counter SHALL compare against the latched nblocks; a change on the nblocks port mid-job has no effect.
REQ-015 Output when not valid: unit_in=0, w_data=0, w_idx=0.

Reset
REQ-016 rst SHALL force IDLE and set busy, done, in_ready, unit_run, w_valid and all data/index outputs to 0; buffer contents are don't-care.
REQ-017 Reset asserted mid-job SHALL abort the job with no done pulse; the first job after reset behaves identically to one issued from power-up.

Structure
REQ-018 A shared package SHALL hold the state enum and the constants NWORDS=16, NSCHED=64, FEED_LAT=17 (run to first computed word), GAP_CYC=1.
REQ-019 The 16x DATA_W word buffer (write port indexed by LOAD counter, read port indexed by FEED counter) SHALL be sub-module msched_wbuf.

Verification
REQ-020 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), nblocks=1 -> W16=0x61626380 at c18, W17=0x000F0000 at c19, 64 w_valid cycles, done once, W63 matching the FIPS 180-4 golden model.
REQ-021 nblocks=3, back-to-back input -> 192 w_valid words, w_idx wrapping 63->0 per block, one done, busy continuous.
REQ-022 nblocks=0 -> done one cycle after start, no unit_run, no w_valid.
REQ-023 in_valid toggled randomly during LOAD -> identical w_data sequence to the unstalled case.
REQ-024 rst asserted at c30 of block 2 -> all outputs 0 next cycle, no done; new job with nblocks=1 matches REQ-020.
REQ-025 start pulsed during FEED -> ignored; nblocks and the block count unchanged.
